merge_pipe: RTL and testbench
=============================

# merge_pipe

Registered, parametrised flit-merge stage for the carpool bufferless router, placed between the input latches and the permutation/arbitration stage. Each cycle it compares all valid input flits pairwise on (address/flow ID, destination, flit ID) and keeps the lowest-indexed flit of each matching group. That survivor's source list becomes the OR of the whole group, and every other member of the group is killed. The result is registered with a stall/hold control. An optional saturating counter records merge activity for performance profiling.

## Interface
Parameters:
- NUM_PORT, 5, number of router input ports (2..8)
- SRC_LIST_WIDTH, 16, source-list bit vector width
- ADDR_WIDTH, 32, address/flow-ID width
- DST_WIDTH, 4, destination ID width
- FLITID_WIDTH, 3, flit sequence ID width
- CNT_WIDTH, 16, merge statistics counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  1 = hold all output registers
- in_valid  in  NUM_PORT  per-port flit present (bit i = port i)
- in_src_list  in  NUM_PORT*SRC_LIST_WIDTH  port i at [i*SRC_LIST_WIDTH +: SRC_LIST_WIDTH]
- in_addr  in  NUM_PORT*ADDR_WIDTH  packed the same way
- in_dst  in  NUM_PORT*DST_WIDTH  packed the same way
- in_flit_id  in  NUM_PORT*FLITID_WIDTH  packed the same way
- out_valid  out  NUM_PORT  registered in_valid & ~kill
- out_kill  out  NUM_PORT  registered kill mask
- out_src_list  out  NUM_PORT*SRC_LIST_WIDTH  registered merged source lists
- clear_stats  in  1  synchronous counter clear (present only with MERGE_STATS_EN)
- merge_cnt  out  CNT_WIDTH  saturating count of killed flits (present only with MERGE_STATS_EN)

## Operation
- match[i][j] for i<j = in_valid[i] & in_valid[j] & addr, dst and flit_id of port i equal to those of port j. match[i][i] and match[i][j] for i>j are 0.
- kill[j] = OR over all i<j of match[i][j]. kill[0] is always 0.
- Matching is an equivalence relation, so every group of matching flits has exactly one survivor: its lowest-indexed member.
- Survivor port i: src_new[i] = src[i] | OR over all j>i of (match[i][j] ? src[j] : 0). Every matching port is included, not only the first match.
- Killed port, or invalid port: src_new is 0 and out_valid is 0.
- Fields of invalid ports never participate in matching, whatever their values (including X).

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- stall=1 at an edge: out_valid, out_kill, out_src_list and merge_cnt all hold their values; the inputs are ignored.
- rst_n=0 at an edge takes priority over stall and all other inputs; the next cycle shows out_valid=0, out_kill=0, out_src_list=0, merge_cnt=0.
- Reset asserted mid-stream: flits captured in the output registers are discarded; there is no partial update.
- Purely combinational path from inputs to outputs: none. All outputs come directly from flops.

## Configuration
- MERGE_STATS_EN defined:
  - On each non-stalled, non-reset edge, merge_cnt += popcount(kill).
  - merge_cnt saturates at 2^CNT_WIDTH-1 and never wraps.
  - clear_stats=1 loads 0 and wins over a simultaneous increment; clear_stats has no effect while stall=1.
- MERGE_STATS_EN undefined:
  - clear_stats and merge_cnt are absent, and no counter logic is generated.
  - All other behaviour is identical.

## Test plan
All scenarios use the default parameters.
- No match: valid=5'b11111 with all addresses distinct -> next cycle out_kill=0, out_valid=5'b11111, each out_src_list equals its input.
- Three-way merge: ports 1, 3 and 4 share addr=0x40, dst=2, flit_id=1 with src 0x0002/0x0008/0x0010 -> out_kill=5'b11000, out_src_list[1]=0x001A, out_valid=5'b00111, merge_cnt +2.
- Partial-field mismatch: ports 0 and 2 have the same addr and dst but flit_id 0 vs 1 -> no kill. Invalid port 3 with fields equal to port 0 -> no kill, and out_src_list[3]=0.
- Stall hold: capture the three-way merge result, then stall=1 for 3 cycles while inputs change -> outputs and merge_cnt are unchanged. Deassert stall -> the new inputs appear 1 cycle later.
- Saturation and clear (CNT_WIDTH=4): drive kill popcount 4 per cycle for 5 cycles -> merge_cnt=15. Then clear_stats=1 while a merge is present -> merge_cnt=0.
- Reset mid-stream: rst_n=0 with stall=1 and registers holding merged data -> next cycle all outputs are 0. Release rst_n -> normal 1-cycle operation resumes.

Source files
------------

// File: rtl/merge_pipe_if.sv
// merge_pipe_if: flit bundle between the input latches and the merge stage.
// master drives the input flits, slave is the merge stage producing merged flits.
interface merge_pipe_if #(
    parameter int NUM_PORT       = 5,
    parameter int SRC_LIST_WIDTH = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int DST_WIDTH      = 4,
    parameter int FLITID_WIDTH   = 3
) ();
    logic [NUM_PORT-1:0]                in_valid;
    logic [NUM_PORT*SRC_LIST_WIDTH-1:0] in_src_list;
    logic [NUM_PORT*ADDR_WIDTH-1:0]     in_addr;
    logic [NUM_PORT*DST_WIDTH-1:0]      in_dst;
    logic [NUM_PORT*FLITID_WIDTH-1:0]   in_flit_id;
    logic [NUM_PORT-1:0]                out_valid;
    logic [NUM_PORT-1:0]                out_kill;
    logic [NUM_PORT*SRC_LIST_WIDTH-1:0] out_src_list;

    modport master (
        output in_valid, in_src_list, in_addr, in_dst, in_flit_id,
        input  out_valid, out_kill, out_src_list
    );

    modport slave (
        input  in_valid, in_src_list, in_addr, in_dst, in_flit_id,
        output out_valid, out_kill, out_src_list
    );
endinterface

// File: rtl/merge_pipe.sv
// merge_pipe: registered flit-merge stage of the carpool bufferless router.
// Optional merge statistics counter enabled by defining MERGE_STATS_EN.
module merge_pipe #(
    parameter int NUM_PORT       = 5,
    parameter int SRC_LIST_WIDTH = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int DST_WIDTH      = 4,
    parameter int FLITID_WIDTH   = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
`ifdef MERGE_STATS_EN
    input  logic                 clear_stats,
    output logic [CNT_WIDTH-1:0] merge_cnt,
`endif
    merge_pipe_if.slave          bus
);
    localparam int SW = SRC_LIST_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DST_WIDTH;
    localparam int FW = FLITID_WIDTH;

    logic [NUM_PORT-1:0][NUM_PORT-1:0] match;
    logic [NUM_PORT-1:0]               kill_d;
    logic [NUM_PORT-1:0]               valid_d;
    logic [NUM_PORT*SW-1:0]            src_d;
    logic [SW-1:0]                     acc;

    logic [NUM_PORT-1:0]               kill_q;
    logic [NUM_PORT-1:0]               valid_q;
    logic [NUM_PORT*SW-1:0]            src_q;

    // Pairwise match, kill mask and OR-merged source lists of survivors
    always_comb begin
        match   = '0;
        kill_d  = '0;
        valid_d = '0;
        src_d   = '0;
        acc     = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            for (int j = i + 1; j < NUM_PORT; j++) begin
                match[i][j] = bus.in_valid[i] & bus.in_valid[j]
                    & (bus.in_addr[i*AW +: AW] == bus.in_addr[j*AW +: AW])
                    & (bus.in_dst[i*DW +: DW] == bus.in_dst[j*DW +: DW])
                    & (bus.in_flit_id[i*FW +: FW] == bus.in_flit_id[j*FW +: FW]);
            end
        end
        for (int j = 0; j < NUM_PORT; j++) begin
            for (int i = 0; i < j; i++) begin
                kill_d[j] = kill_d[j] | match[i][j];
            end
        end
        for (int i = 0; i < NUM_PORT; i++) begin
            acc = bus.in_src_list[i*SW +: SW];
            for (int j = i + 1; j < NUM_PORT; j++) begin
                if (match[i][j]) begin
                    acc = acc | bus.in_src_list[j*SW +: SW];
                end
            end
            valid_d[i] = bus.in_valid[i] & ~kill_d[i];
            if (valid_d[i]) begin
                src_d[i*SW +: SW] = acc;
            end
        end
    end

    // Output registers: reset clears, stall holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            kill_q  <= '0;
            src_q   <= '0;
        end else if (!stall) begin
            valid_q <= valid_d;
            kill_q  <= kill_d;
            src_q   <= src_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_kill     = kill_q;
    assign bus.out_src_list = src_q;

`ifdef MERGE_STATS_EN
    logic [CNT_WIDTH:0]   pop;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] merge_cnt_d;
    logic [CNT_WIDTH-1:0] merge_cnt_q;

    // Saturating add of this cycle's kill popcount
    always_comb begin
        pop = '0;
        for (int j = 0; j < NUM_PORT; j++) begin
            pop = pop + (CNT_WIDTH+1)'(kill_d[j]);
        end
        sum         = {1'b0, merge_cnt_q} + pop;
        merge_cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end

    // Statistics counter: reset, stall hold, clear beats increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            merge_cnt_q <= '0;
        end else if (!stall) begin
            if (clear_stats) begin
                merge_cnt_q <= '0;
            end else begin
                merge_cnt_q <= merge_cnt_d;
            end
        end
    end

    assign merge_cnt = merge_cnt_q;
`endif
endmodule

// File: tb/tb_merge_pipe.sv
// tb_merge_pipe: scoreboard bench for merge_pipe.
// Counter checks are active when MERGE_STATS_EN is defined.
module tb_merge_pipe;
    localparam int NP = 5;
    localparam int SW = 16;

    typedef struct {
        string       name;
        logic [4:0]  v;
        logic [4:0]  k;
        logic [79:0] s;
        logic [3:0]  c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic clear_stats = 1'b0;
    logic [3:0] merge_cnt;

    logic [NP-1:0]    vld = '0;
    logic [NP*16-1:0] src = '0;
    logic [NP*32-1:0] adr = '0;
    logic [NP*4-1:0]  dst = '0;
    logic [NP*3-1:0]  fid = '0;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    merge_pipe_if #(.NUM_PORT(NP)) bus ();

    assign bus.in_valid    = vld;
    assign bus.in_src_list = src;
    assign bus.in_addr     = adr;
    assign bus.in_dst      = dst;
    assign bus.in_flit_id  = fid;

`ifndef MERGE_STATS_EN
    assign merge_cnt = '0;
`endif

    merge_pipe #(.NUM_PORT(NP), .CNT_WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
`ifdef MERGE_STATS_EN
        .clear_stats(clear_stats),
        .merge_cnt(merge_cnt),
`endif
        .bus(bus)
    );

    function automatic logic [79:0] pk(input logic [15:0] s0, input logic [15:0] s1,
                                       input logic [15:0] s2, input logic [15:0] s3,
                                       input logic [15:0] s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    task automatic clr_in();
        vld = '0;
        src = '0;
        adr = '0;
        dst = '0;
        fid = '0;
    endtask

    task automatic setp(input int i, input logic v, input logic [31:0] a,
                        input logic [3:0] d, input logic [2:0] f, input logic [15:0] s);
        vld[i]        = v;
        adr[i*32 +: 32] = a;
        dst[i*4 +: 4]   = d;
        fid[i*3 +: 3]   = f;
        src[i*16 +: 16] = s;
    endtask

    task automatic tick(input string nm, input logic [4:0] ev, input logic [4:0] ek,
                        input logic [79:0] es, input logic [3:0] ec);
        exp_t e;
        e.name = nm;
        e.v = ev;
        e.k = ek;
        e.s = es;
        e.c = ec;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic no_match();
        clr_in();
        for (int i = 0; i < NP; i++) begin
            setp(i, 1'b1, 32'h100 * i + 1, 4'(i), 3'd0, 16'h1111 * 16'(i + 1));
        end
    endtask

    task automatic three_way();
        clr_in();
        setp(0, 1'b1, 32'h10, 4'd2, 3'd1, 16'h0001);
        setp(1, 1'b1, 32'h40, 4'd2, 3'd1, 16'h0002);
        setp(2, 1'b1, 32'h20, 4'd2, 3'd1, 16'h0004);
        setp(3, 1'b1, 32'h40, 4'd2, 3'd1, 16'h0008);
        setp(4, 1'b1, 32'h40, 4'd2, 3'd1, 16'h0010);
    endtask

    task automatic all_five();
        clr_in();
        setp(0, 1'b1, 32'h77, 4'd5, 3'd2, 16'h0001);
        setp(1, 1'b1, 32'h77, 4'd5, 3'd2, 16'h0010);
        setp(2, 1'b1, 32'h77, 4'd5, 3'd2, 16'h0100);
        setp(3, 1'b1, 32'h77, 4'd5, 3'd2, 16'h1000);
        setp(4, 1'b1, 32'h77, 4'd5, 3'd2, 16'h8000);
    endtask

    // Monitor: compare each registered output against the next expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.out_valid !== e.v) begin
                errors++;
                $display("FAIL %s valid got %b exp %b", e.name, bus.out_valid, e.v);
            end
            checks++;
            if (bus.out_kill !== e.k) begin
                errors++;
                $display("FAIL %s kill got %b exp %b", e.name, bus.out_kill, e.k);
            end
            checks++;
            if (bus.out_src_list !== e.s) begin
                errors++;
                $display("FAIL %s src got %h exp %h", e.name, bus.out_src_list, e.s);
            end
`ifdef MERGE_STATS_EN
            checks++;
            if (merge_cnt !== e.c) begin
                errors++;
                $display("FAIL %s cnt got %0d exp %0d", e.name, merge_cnt, e.c);
            end
`endif
        end
    end

    localparam logic [79:0] NM_S = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

    initial begin
        @(negedge clk);
        clr_in();
        rst_n = 1'b0;
        tick("reset", 5'b00000, 5'b00000, '0, 4'd0);
        rst_n = 1'b1;

        no_match();
        tick("nomatch", 5'b11111, 5'b00000, NM_S, 4'd0);

        three_way();
        tick("three_way", 5'b00111, 5'b11000,
             pk(16'h0001, 16'h001A, 16'h0004, 16'h0000, 16'h0000), 4'd2);

        clr_in();
        setp(0, 1'b1, 32'h55, 4'd3, 3'd0, 16'h0100);
        setp(1, 1'b1, 32'h66, 4'd3, 3'd0, 16'h0400);
        setp(2, 1'b1, 32'h55, 4'd3, 3'd1, 16'h0200);
        setp(3, 1'b0, 32'h55, 4'd3, 3'd0, 16'hFFFF);
        setp(4, 1'b0, 32'h55, 4'd3, 3'd0, 16'hABCD);
        tick("partial", 5'b00111, 5'b00000,
             pk(16'h0100, 16'h0400, 16'h0200, 16'h0000, 16'h0000), 4'd2);

        clr_in();
        setp(0, 1'b1, 32'hA0, 4'd1, 3'd4, 16'h0001);
        setp(1, 1'b1, 32'hB0, 4'd6, 3'd7, 16'h0020);
        setp(2, 1'b1, 32'hA0, 4'd1, 3'd4, 16'h0300);
        setp(3, 1'b1, 32'hA0, 4'd1, 3'd5, 16'h4000);
        setp(4, 1'b1, 32'hB0, 4'd6, 3'd7, 16'h0800);
        tick("two_groups", 5'b01011, 5'b10100,
             pk(16'h0301, 16'h0820, 16'h0000, 16'h4000, 16'h0000), 4'd4);

        three_way();
        tick("stall_cap", 5'b00111, 5'b11000,
             pk(16'h0001, 16'h001A, 16'h0004, 16'h0000, 16'h0000), 4'd6);
        stall = 1'b1;
        no_match();
        for (int n = 0; n < 3; n++) begin
            if (n == 1) all_five();
            if (n == 2) no_match();
            tick("stall_hold", 5'b00111, 5'b11000,
                 pk(16'h0001, 16'h001A, 16'h0004, 16'h0000, 16'h0000), 4'd6);
        end
        stall = 1'b0;
        tick("stall_rel", 5'b11111, 5'b00000, NM_S, 4'd6);

        all_five();
        tick("sat1", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd10);
        tick("sat2", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd14);
        tick("sat3", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd15);
        tick("sat4", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd15);
        tick("sat5", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd15);
        clear_stats = 1'b1;
        stall = 1'b1;
        tick("clr_stalled", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd15);
        stall = 1'b0;
        tick("clear", 5'b00001, 5'b11110, pk(16'h9111, 0, 0, 0, 0), 4'd0);
        clear_stats = 1'b0;

        three_way();
        tick("pre_rst", 5'b00111, 5'b11000,
             pk(16'h0001, 16'h001A, 16'h0004, 16'h0000, 16'h0000), 4'd2);
        stall = 1'b1;
        rst_n = 1'b0;
        tick("mid_rst", 5'b00000, 5'b00000, '0, 4'd0);
        rst_n = 1'b1;
        stall = 1'b0;
        no_match();
        tick("post_rst", 5'b11111, 5'b00000, NM_S, 4'd0);
        three_way();
        tick("post_rst_m", 5'b00111, 5'b11000,
             pk(16'h0001, 16'h001A, 16'h0004, 16'h0000, 16'h0000), 4'd2);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
